// File: rtl/program_loader_if.sv
// Host word stream and memory write port of the boot-time program loader.
// The loader side uses the slave modport; the host/memory side uses master.
interface program_loader_if #(
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_SIZE-1:0]  in_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: streams words into memory 0..MEM_DEPTH-1, verifies a
// trailing modular-sum checksum and releases the CPU from reset only on success.
module program_loader #(
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    program_loader_if.slave        bus,
    output logic                   cpu_reset,
    output logic                   loaded,
    output logic                   load_error
);
    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic [WORD_SIZE-1:0]  sum_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WORD_SIZE-1:0]  mem_wdata_q;
    logic                  cpu_reset_q;
    logic                  loaded_q;
    logic                  load_error_q;

    logic                  in_ready_d;
    logic                  accept_d;
    logic [WORD_SIZE-1:0]  sum_d;

    // load_start blocks the handshake so a restart never swallows a host beat
    always_comb begin
        in_ready_d = 1'b0;
        if (((state_q == LOAD) || (state_q == CHECK)) && !load_start) begin
            in_ready_d = 1'b1;
        end else begin
            in_ready_d = 1'b0;
        end
        accept_d = in_ready_d & bus.in_valid;
        sum_d    = sum_q + bus.in_data;
    end

    // Loader state machine with registered memory port and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_cnt_q   <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            loaded_q     <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (load_start) begin
                state_q      <= LOAD;
                addr_cnt_q   <= '0;
                sum_q        <= '0;
                cpu_reset_q  <= 1'b1;
                loaded_q     <= 1'b0;
                load_error_q <= 1'b0;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (accept_d) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_cnt_q;
                            mem_wdata_q <= bus.in_data;
                            sum_q       <= sum_d;
                            addr_cnt_q  <= addr_cnt_q + 1'b1;
                            if (addr_cnt_q == LAST_ADDR) begin
                                state_q <= CHECK;
                            end else begin
                                state_q <= LOAD;
                            end
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                    CHECK: begin
                        if (accept_d) begin
                            if (bus.in_data == sum_q) begin
                                state_q     <= RUN;
                                cpu_reset_q <= 1'b0;
                                loaded_q    <= 1'b1;
                            end else begin
                                state_q      <= ERROR;
                                load_error_q <= 1'b1;
                            end
                        end else begin
                            state_q <= CHECK;
                        end
                    end
                    IDLE, RUN, ERROR: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q      <= IDLE;
                        cpu_reset_q  <= 1'b1;
                        loaded_q     <= 1'b0;
                        load_error_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign loaded        = loaded_q;
    assign load_error    = load_error_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: the driver queues expected memory
// writes, a forked monitor pops and compares them on every mem_we pulse.
module tb_program_loader;
    logic clk;
    logic reset;
    logic load_start;
    logic cpu_reset;
    logic loaded;
    logic load_error;

    program_loader_if #(.WORD_SIZE(4), .ADDR_WIDTH(4)) ifc ();

    program_loader #(.WORD_SIZE(4), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .bus        (ifc.slave),
        .cpu_reset  (cpu_reset),
        .loaded     (loaded),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_pass;
    int         n_total;
    logic [7:0] exp_q[$];
    logic [3:0] exp_addr;
    logic [3:0] words[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (ifc.mem_we !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {ifc.mem_addr, ifc.mem_wdata}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_write", {24'd0, ifc.mem_addr, ifc.mem_wdata}, {24'd0, e});
                end
            end
        end
    endtask

    task automatic send_word(input logic [3:0] w, input bit wr, input int gap);
        int n;
        int g;
        @(negedge clk);
        g = 0;
        while (($urandom_range(0, 99) < gap) && (g < 8)) begin
            ifc.in_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        ifc.in_valid = 1'b1;
        ifc.in_data  = w;
        #1;
        n = 0;
        while ((ifc.in_ready !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ifc.in_ready !== 1'b1) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            if (wr) begin
                exp_q.push_back({exp_addr, w});
                exp_addr = exp_addr + 4'd1;
            end
            @(posedge clk);
        end
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        exp_addr   = 4'd0;
    endtask

    task automatic full_load(input logic [3:0] chk, input int gap);
        for (int i = 0; i < 16; i++) send_word(words[i], 1'b1, gap);
        send_word(chk, 1'b0, gap);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_status(input string tag, input logic cr, input logic ld, input logic le);
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
        check({tag, "_loaded"}, {31'd0, loaded}, {31'd0, ld});
        check({tag, "_load_error"}, {31'd0, load_error}, {31'd0, le});
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        exp_addr     = 4'd0;
        reset        = 1'b1;
        load_start   = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 4'd0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_status("reset", 1'b1, 1'b0, 1'b0);
        check("reset_mem_we", {31'd0, ifc.mem_we}, 32'd0);
        check("reset_mem_addr", {28'd0, ifc.mem_addr}, 32'd0);
        check("reset_mem_wdata", {28'd0, ifc.mem_wdata}, 32'd0);
        check("reset_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        reset = 1'b0;

        // Test 1: words 0..15 back-to-back, checksum 8
        for (int i = 0; i < 16; i++) words[i] = 4'(i);
        pulse_start();
        full_load(4'h8, 0);
        check_status("t1_run", 1'b0, 1'b1, 1'b0);

        // Test 6: restart from RUN
        pulse_start();
        @(negedge clk);
        check_status("t6_restart", 1'b1, 1'b0, 1'b0);
        full_load(4'h8, 0);
        check_status("t6_run", 1'b0, 1'b1, 1'b0);

        // Test 2: bad checksum
        pulse_start();
        full_load(4'h9, 0);
        check_status("t2_error", 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_status("t2_hold", 1'b1, 1'b0, 1'b1);
        check("t2_in_ready", {31'd0, ifc.in_ready}, 32'd0);

        // Test 3: all 0xF with gaps, checksum 0
        for (int i = 0; i < 16; i++) words[i] = 4'hF;
        pulse_start();
        full_load(4'h0, 50);
        check_status("t3_run", 1'b0, 1'b1, 1'b0);

        // Test 4: restart after 5 words with a concurrent beat
        for (int i = 0; i < 16; i++) words[i] = 4'(i);
        pulse_start();
        for (int i = 0; i < 5; i++) send_word(words[i], 1'b1, 0);
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 4'h7;
        load_start   = 1'b1;
        #1;
        check("t4_ready_blocked", {31'd0, ifc.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        load_start   = 1'b0;
        ifc.in_valid = 1'b0;
        exp_addr     = 4'd0;
        full_load(4'h8, 0);
        check_status("t4_run", 1'b0, 1'b1, 1'b0);

        // Test 5: reset after 7 words, then a clean reload
        pulse_start();
        for (int i = 0; i < 7; i++) send_word(words[i], 1'b1, 0);
        @(negedge clk);
        reset        = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 4'h3;
        repeat (3) @(negedge clk);
        check_status("t5_reset", 1'b1, 1'b0, 1'b0);
        check("t5_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        reset        = 1'b0;
        ifc.in_valid = 1'b0;
        check("t5_queue_empty", exp_q.size(), 32'd0);
        pulse_start();
        full_load(4'h8, 0);
        check_status("t5_run", 1'b0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
